// File: rtl/div3_pkg.sv
// Shared types and constants for the divide-by-3 datapath.
package div3_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned DIVISOR       = 3;
  localparam int unsigned DEFAULT_WIDTH = 32;

  // Iteration counter width; a 1-bit floor keeps tiny widths legal.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/div3_step.sv
// One restoring division step by the constant divisor: shifts a dividend bit
// into the 2-bit partial remainder and subtracts the divisor when it fits.
module div3_step
  import div3_pkg::*;
(
  input  logic [1:0] r,
  input  logic       dbit,
  output logic [1:0] r_next,
  output logic       qbit
);

  logic [2:0] t;
  logic [2:0] diff;

  assign t      = {r, dbit};
  assign diff   = t - 3'(DIVISOR);
  assign qbit   = (t >= 3'(DIVISOR));
  // r <= 2 on entry keeps t <= 5, so the difference always fits in 2 bits
  assign r_next = qbit ? diff[1:0] : t[1:0];

endmodule

// File: rtl/div_by_3_32.sv
// Sequential exact divider by 3: one restoring step per cycle, WIDTH cycles
// per operand, registered quotient/remainder with a one-cycle valid pulse.
module div_by_3_32
  import div3_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] out,
  output logic [1:0]       rem,
  output logic             valid,
  output logic             busy
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   d;
  logic [WIDTH-1:0]   q;
  logic [1:0]         r;
  logic [CNT_W-1:0]   cnt;

  logic               load_c;
  logic               step_c;
  logic               last_c;
  logic [1:0]         r_nxt;
  logic               qbit;
  logic [WIDTH-1:0]   q_nxt;

  div3_step u_step (
    .r      (r),
    .dbit   (d[WIDTH-1]),
    .r_next (r_nxt),
    .qbit   (qbit)
  );

  assign q_nxt = {q[WIDTH-2:0], qbit};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (en) state_nxt = RUN;
      RUN:  if (cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control decode
  always_comb begin
    load_c = 1'b0;
    step_c = 1'b0;
    last_c = 1'b0;
    case (state)
      IDLE: load_c = en;
      RUN: begin
        step_c = 1'b1;
        last_c = (cnt == '0);
      end
      default: ;
    endcase
  end

  // Shift registers, counter and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d     <= '0;
      q     <= '0;
      r     <= '0;
      cnt   <= '0;
      out   <= '0;
      rem   <= '0;
      valid <= 1'b0;
      busy  <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (load_c) begin
        d    <= x;
        q    <= '0;
        r    <= '0;
        cnt  <= CNT_W'(WIDTH - 1);
        busy <= 1'b1;
      end else if (step_c) begin
        d   <= {d[WIDTH-2:0], 1'b0};
        q   <= q_nxt;
        r   <= r_nxt;
        cnt <= cnt - CNT_W'(1);
        if (last_c) begin
          out   <= q_nxt;
          rem   <= r_nxt;
          valid <= 1'b1;
          busy  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_div_by_3_32.sv
// Randomized scoreboard bench for div_by_3_32 against plain x/3 and x%3.
module tb_div_by_3_32;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [W-1:0]  x;
  logic [W-1:0]  out;
  logic [1:0]    rem;
  logic          valid;
  logic          busy;

  typedef struct {
    logic [W-1:0] q;
    logic [1:0]   r;
    int unsigned  cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  int          valid_seen = 0;

  div_by_3_32 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .x     (x),
    .out   (out),
    .rem   (rem),
    .valid (valid),
    .busy  (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] v, input int unsigned c);
    exp_t e;
    e.q   = v / 3;
    e.r   = 2'(v % 3);
    e.cyc = c;
    return e;
  endfunction

  // Monitor: every valid pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst) begin
      if (valid && busy) check("valid_busy_overlap", 64'd1, 64'd0);
      if (valid) begin
        valid_seen++;
        if (sb.size() == 0) begin
          check("unexpected_valid", 64'd1, 64'd0);
        end else begin
          mon_e = sb.pop_front();
          check("quotient", 64'(out), 64'(mon_e.q));
          check("remainder", 64'(rem), 64'(mon_e.r));
          check("latency", 64'(cyc - mon_e.cyc), 64'(W));
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (busy) check("idle_timeout", 64'd1, 64'd0);
  endtask

  // Pulse en for one edge with operand v and register its expected result
  task automatic start_op(input logic [W-1:0] v);
    wait_idle();
    x  = v;
    en = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back(model(v, cyc));
    en = 1'b0;
    x  = $urandom;
  endtask

  task automatic wait_valid(output int busy_cycles);
    int n0 = valid_seen;
    bit got = 0;
    busy_cycles = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      #1;
      if (valid_seen != n0) got = 1;
    end
    if (!got) check("valid_timeout", 64'd1, 64'd0);
  endtask

  task automatic run_op(input logic [W-1:0] v);
    int bc;
    start_op(v);
    wait_valid(bc);
  endtask

  initial begin
    int bc;
    int n0;
    rst = 1'b1;
    en  = 1'b0;
    x   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out", 64'(out), 64'd0);
    check("reset_rem", 64'(rem), 64'd0);
    check("reset_valid", 64'(valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // First operation also measures the busy window
    start_op(32'd6);
    wait_valid(bc);
    check("busy_cycles", 64'(bc), 64'(W));

    run_op(32'd7);
    run_op(32'd2);
    run_op(32'd0);
    run_op(32'hFFFF_FFFF);
    run_op(32'hFFFF_FFFE);

    // Requests during RUN are dropped, not queued
    n0 = valid_seen;
    start_op(32'd9);
    repeat (5) @(posedge clk);
    #1;
    en = 1'b1;
    x  = 32'd100;
    @(posedge clk);
    #1;
    en = 1'b0;
    @(posedge clk);
    #1;
    en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    wait_valid(bc);
    repeat (40) @(negedge clk);
    #1;
    check("single_valid", 64'(valid_seen - n0), 64'd1);

    // Asynchronous abort mid-run
    n0 = valid_seen;
    start_op(32'd300);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_out", 64'(out), 64'd0);
    check("abort_rem", 64'(rem), 64'd0);
    check("abort_valid", 64'(valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    #1;
    check("abort_no_valid", 64'(valid_seen - n0), 64'd0);
    run_op(32'd12);

    // en held high: back-to-back loads WIDTH+1 cycles apart
    wait_idle();
    x  = 32'd3;
    en = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back(model(32'd3, cyc));
    sb.push_back(model(32'd6, cyc + W + 1));
    x = 32'd6;
    wait_valid(bc);
    @(posedge clk);
    #1;
    en = 1'b0;
    x  = 32'd55;
    wait_valid(bc);

    for (int i = 0; i < 20; i++) begin
      run_op(W'($urandom));
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
